// File: rtl/uart_pkg.sv
// Shared state encodings, idle line level and frame-length helper for the UART core.
// Defining UART_PARITY_EN adds the even-parity state to both FSMs.
package uart_pkg;

  localparam logic UART_IDLE_LVL = 1'b1;

`ifdef UART_PARITY_EN
  localparam int UART_PARITY_BITS = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT
  } rx_state_e;
`else
  localparam int UART_PARITY_BITS = 0;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;
`endif

  // Bits on the line for one frame: start + data + optional parity + stop bits.
  function automatic int uart_frame_bits(input int data_w, input int stop_bits);
    return 1 + data_w + UART_PARITY_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART core: circular buffer with occupancy count and sticky overflow.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head     = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !do_push) begin
      overflow_d = 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART on the system clock: TX serializer, mid-bit RX sampler and RX FIFO.
// Define UART_PARITY_EN for an even parity bit on both directions plus the parity_err pulse.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_tx,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_busy,
  output logic              tx,
  input  logic              rx,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic              overflow,
  output logic              frame_err
`ifdef UART_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  tx_state_e         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic              tx_stop_q, tx_stop_d;
  logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
  logic              tx_q, tx_d;
  logic              tx_cnt_last, tx_done, tx_accept;

  rx_state_e         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_cnt_last, rx_push;

  logic              fifo_full, fifo_empty;

`ifdef UART_PARITY_EN
  logic              tx_par_q, tx_par_d;
  logic              rx_par_q, rx_par_d;
  logic              rx_bad_q, rx_bad_d;
  logic              parity_err_q, parity_err_d;
  assign parity_err = parity_err_q;
`endif

  assign tx_cnt_last = (tx_cnt_q == CNT_LAST);
  assign rx_cnt_last = (rx_cnt_q == CNT_LAST);

  // tx_busy drops in the final stop-bit cycle so a new start_tx follows with no idle gap.
  assign tx_done    = (tx_state_q == TX_STOP) && tx_cnt_last && (tx_stop_q == STOP_LAST);
  assign tx_busy    = (tx_state_q != TX_IDLE) && !tx_done;
  assign tx_accept  = start_tx && !tx_busy;
  assign tx         = tx_q;
  assign frame_err  = frame_err_q;
  assign data_ready = !fifo_empty;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_last ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shreg_d = tx_shreg_q;
    tx_d       = tx_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif

    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = UART_IDLE_LVL;
      end
      TX_START: begin
        if (tx_cnt_last) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          tx_d       = tx_shreg_q[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_last) begin
          if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = TX_STOP;
            tx_stop_d  = 1'b0;
            tx_d       = UART_IDLE_LVL;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shreg_d = tx_shreg_q >> 1;
            tx_d       = tx_shreg_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_last) begin
          tx_state_d = TX_STOP;
          tx_stop_d  = 1'b0;
          tx_d       = UART_IDLE_LVL;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_last) begin
          if (tx_stop_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
            tx_d       = UART_IDLE_LVL;
          end else begin
            tx_stop_d = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Acceptance overrides both IDLE and the last stop cycle.
    if (tx_accept) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_shreg_d = data_in;
      tx_d       = ~UART_IDLE_LVL;
`ifdef UART_PARITY_EN
      tx_par_d   = ^data_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shreg_q <= '0;
      tx_q       <= UART_IDLE_LVL;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shreg_q <= tx_shreg_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // The counter starts at 1 on the detected edge so the re-check lands mid start bit.
  always_comb begin
    rx_meta_d   = rx;
    rx_sync_d   = rx_meta_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_last ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shreg_d  = rx_shreg_q;
    frame_err_d = 1'b0;
    rx_push     = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d     = rx_par_q;
    rx_bad_d     = rx_bad_q;
    parity_err_d = 1'b0;
`endif

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_sync_q != UART_IDLE_LVL) begin
          rx_state_d = RX_START;
          rx_cnt_d   = CW'(1);
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_sync_q != UART_IDLE_LVL) begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
`ifdef UART_PARITY_EN
            rx_par_d   = 1'b0;
            rx_bad_d   = 1'b0;
`endif
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_last) begin
          rx_shreg_d = {rx_sync_q, rx_shreg_q[DATA_W-1:1]};
`ifdef UART_PARITY_EN
          rx_par_d   = rx_par_q ^ rx_sync_q;
`endif
          if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_last) begin
          rx_state_d = RX_STOP;
          if (rx_par_q ^ rx_sync_q) begin
            parity_err_d = 1'b1;
            rx_bad_d     = 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_last) begin
          if (rx_sync_q == UART_IDLE_LVL) begin
            rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
            rx_push    = !rx_bad_q;
`else
            rx_push    = 1'b1;
`endif
          end else begin
            rx_state_d  = RX_WAIT;
            frame_err_d = 1'b1;
          end
        end
      end
      RX_WAIT: begin
        rx_cnt_d = '0;
        if (rx_sync_q == UART_IDLE_LVL) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= UART_IDLE_LVL;
      rx_sync_q   <= UART_IDLE_LVL;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shreg_q  <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q     <= 1'b0;
      rx_bad_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shreg_q  <= rx_shreg_d;
      frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
      rx_par_q     <= rx_par_d;
      rx_bad_q     <= rx_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shreg_q),
    .pop       (rd_en),
    .head      (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

endmodule
